// File: rtl/instr_fetch_unit_if.sv
// Fetch-stage bus bundle: instruction memory port, IR handoff to decode
// and the branch/jump redirect coming back from execute.
interface instr_fetch_unit_if;
    logic [31:0] imem_addr;
    logic [31:0] imem_data;
    logic [31:0] ir;
    logic [31:0] ir_pc4;
    logic        ir_valid;
    logic        ir_ready;
    logic        redir_valid;
    logic [31:0] redir_pc4;
    logic [15:0] redir_imm;

    // Fetch unit side
    modport master (
        output imem_addr,
        input  imem_data,
        output ir,
        output ir_pc4,
        output ir_valid,
        input  ir_ready,
        input  redir_valid,
        input  redir_pc4,
        input  redir_imm
    );

    // Memory / decode / execute side
    modport slave (
        input  imem_addr,
        output imem_data,
        input  ir,
        input  ir_pc4,
        input  ir_valid,
        output ir_ready,
        output redir_valid,
        output redir_pc4,
        output redir_imm
    );
endinterface

// File: rtl/instr_fetch_unit.sv
// Fetch stage of the multicycle MIPS core. Owns the PC, samples the
// combinational instruction memory into IR, hands IR to decode over a
// valid/ready handshake, applies redirects and spots the terminating JMP -1.
module instr_fetch_unit #(
    parameter logic [31:0] RESET_PC   = 32'h0000_0000,
    parameter int          FETCH_WAIT = 0
) (
    input  logic                       clk,
    input  logic                       rst,
    instr_fetch_unit_if.master         bus,
    output logic                       halted,
    output logic [31:0]                fetch_count
);

    localparam logic [0:0]  ST_WAIT     = 1'b0;
    localparam logic [0:0]  ST_FULL     = 1'b1;
    localparam logic [3:0]  WAIT_CYCLES = 4'(FETCH_WAIT);
    localparam logic [31:0] HALT_INSTR  = 32'hA800_FFFF;

    logic [0:0]  r_state;
    logic [3:0]  r_cnt;
    logic [31:0] r_pc;
    logic [31:0] r_ir;
    logic [31:0] r_ir_pc4;
    logic        r_halted;
    logic [31:0] r_fetch_count;

    logic [0:0]  w_state_next;
    logic [3:0]  w_cnt_next;
    logic [31:0] w_pc_next;
    logic [31:0] w_ir_next;
    logic [31:0] w_ir_pc4_next;
    logic        w_halted_next;
    logic [31:0] w_fetch_count_next;

    logic        w_accept;
    logic        w_sample;
    logic [31:0] w_pc_plus4;
    logic [29:0] w_redir_word;
    logic [31:0] w_redir_target;
    logic        w_unused_pc4_lsbs;

    // Handshake completes whenever IR is full and decode is ready.
    assign w_accept = (r_state == ST_FULL) && bus.ir_ready;

    // Sample memory at the end of the wait window, or back-to-back in
    // zero-wait mode when decode takes the current IR.
    assign w_sample = ((r_state == ST_WAIT) && (r_cnt == WAIT_CYCLES)) ||
                      ((FETCH_WAIT == 0) && w_accept);

    assign w_pc_plus4 = r_pc + 32'd4;

    // Target is computed in word units so the low pc4 bits never leak in;
    // the 30-bit add wraps exactly like the full 32-bit byte address.
    assign w_redir_word   = bus.redir_pc4[31:2] +
                            {{14{bus.redir_imm[15]}}, bus.redir_imm};
    assign w_redir_target = {w_redir_word, 2'b00};
    assign w_unused_pc4_lsbs = ^bus.redir_pc4[1:0];

    // Next-state logic: redirect beats normal fetch; accept side effects
    // are independent of the redirect.
    always_comb begin
        w_state_next       = r_state;
        w_cnt_next         = r_cnt;
        w_pc_next          = r_pc;
        w_ir_next          = r_ir;
        w_ir_pc4_next      = r_ir_pc4;
        w_halted_next      = r_halted;
        w_fetch_count_next = r_fetch_count;

        if (w_accept) begin
            w_fetch_count_next = r_fetch_count + 32'd1;
            if (r_ir == HALT_INSTR) begin
                w_halted_next = 1'b1;
            end
        end

        if (bus.redir_valid) begin
            w_pc_next    = w_redir_target;
            w_state_next = ST_WAIT;
            w_cnt_next   = 4'd0;
        end else if (w_sample) begin
            w_ir_next     = bus.imem_data;
            w_ir_pc4_next = w_pc_plus4;
            w_pc_next     = w_pc_plus4;
            w_state_next  = ST_FULL;
        end else if (r_state == ST_WAIT) begin
            w_cnt_next = r_cnt + 4'd1;
        end else if (w_accept) begin
            w_cnt_next   = 4'd0;
            w_state_next = ST_WAIT;
        end
    end

    // State registers with synchronous reset that overrides everything.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state       <= ST_WAIT;
            r_cnt         <= 4'd0;
            r_pc          <= RESET_PC;
            r_ir          <= 32'd0;
            r_ir_pc4      <= 32'd0;
            r_halted      <= 1'b0;
            r_fetch_count <= 32'd0;
        end else begin
            r_state       <= w_state_next;
            r_cnt         <= w_cnt_next;
            r_pc          <= w_pc_next;
            r_ir          <= w_ir_next;
            r_ir_pc4      <= w_ir_pc4_next;
            r_halted      <= w_halted_next;
            r_fetch_count <= w_fetch_count_next;
        end
    end

    assign bus.imem_addr = r_pc;
    assign bus.ir        = r_ir;
    assign bus.ir_pc4    = r_ir_pc4;
    assign bus.ir_valid  = (r_state == ST_FULL);
    assign halted        = r_halted;
    assign fetch_count   = r_fetch_count;

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Directed bench for instr_fetch_unit: a zero-wait instance and a
// FETCH_WAIT=3 instance share one clock and one preloaded program image.
module tb_instr_fetch_unit;

    logic        clk;
    logic        rst0;
    logic        rst1;
    logic        halted0;
    logic        halted1;
    logic [31:0] fc0;
    logic [31:0] fc1;
    logic [31:0] mem [0:255];
    int          checks;
    int          errors;

    instr_fetch_unit_if bus0 ();
    instr_fetch_unit_if bus1 ();

    instr_fetch_unit #(.RESET_PC(32'h0), .FETCH_WAIT(0)) dut0 (
        .clk         (clk),
        .rst         (rst0),
        .bus         (bus0),
        .halted      (halted0),
        .fetch_count (fc0)
    );

    instr_fetch_unit #(.RESET_PC(32'h0), .FETCH_WAIT(3)) dut1 (
        .clk         (clk),
        .rst         (rst1),
        .bus         (bus1),
        .halted      (halted1),
        .fetch_count (fc1)
    );

    assign bus0.imem_data = mem[bus0.imem_addr[9:2]];
    assign bus1.imem_data = mem[bus1.imem_addr[9:2]];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    initial begin
        checks = 0;
        errors = 0;
        for (int i = 0; i < 256; i++) mem[i] = {16'hC0DE, 16'(i)};
        mem[0]  = 32'h0000_0000;
        mem[1]  = 32'h8001_060A;
        mem[64] = 32'hA800_FFFF;

        rst0 = 1'b1; rst1 = 1'b1;
        bus0.ir_ready = 1'b1; bus0.redir_valid = 1'b0; bus0.redir_pc4 = 32'h0; bus0.redir_imm = 16'h0;
        bus1.ir_ready = 1'b0; bus1.redir_valid = 1'b0; bus1.redir_pc4 = 32'h0; bus1.redir_imm = 16'h0;
        tick(); tick();

        // ---- zero-wait instance ----
        check("rst_valid",  bus0.ir_valid,  32'd0);
        check("rst_addr",   bus0.imem_addr, 32'h0);
        check("rst_ir",     bus0.ir,        32'h0);
        check("rst_pc4",    bus0.ir_pc4,    32'h0);
        check("rst_fc",     fc0,            32'd0);
        check("rst_halted", halted0,        32'd0);

        rst0 = 1'b0;
        tick();
        check("first_valid", bus0.ir_valid, 32'd1);
        check("first_ir",    bus0.ir,       32'h0);
        check("first_pc4",   bus0.ir_pc4,   32'h4);
        check("first_addr",  bus0.imem_addr,32'h4);
        check("first_fc",    fc0,           32'd0);
        tick();
        check("w1_ir",  bus0.ir,     32'h8001_060A);
        check("w1_pc4", bus0.ir_pc4, 32'h8);
        check("w1_fc",  fc0,         32'd1);
        tick();
        check("w2_ir",  bus0.ir,     mem[2]);
        check("w2_fc",  fc0,         32'd2);

        // Stall: everything frozen for 5 cycles
        bus0.ir_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            tick();
            check("stall_valid", bus0.ir_valid,  32'd1);
            check("stall_ir",    bus0.ir,        mem[2]);
            check("stall_pc4",   bus0.ir_pc4,    32'hC);
            check("stall_addr",  bus0.imem_addr, 32'hC);
            check("stall_fc",    fc0,            32'd2);
        end
        bus0.ir_ready = 1'b1;
        tick();
        check("release_ir",  bus0.ir,     mem[3]);
        check("release_pc4", bus0.ir_pc4, 32'h10);
        check("release_fc",  fc0,         32'd3);

        // BNE redirect back to word 34 (no accept this cycle)
        bus0.ir_ready = 1'b0;
        bus0.redir_valid = 1'b1; bus0.redir_pc4 = 32'hC4; bus0.redir_imm = 16'hFFF1;
        tick();
        check("bne_addr",  bus0.imem_addr, 32'h88);
        check("bne_valid", bus0.ir_valid,  32'd0);
        check("bne_fc",    fc0,            32'd3);
        bus0.redir_valid = 1'b0; bus0.ir_ready = 1'b1;
        tick();
        check("bne_ir",    bus0.ir,       mem[34]);
        check("bne_pc4",   bus0.ir_pc4,   32'h8C);
        check("bne_valid2",bus0.ir_valid, 32'd1);
        check("bne_fc2",   fc0,           32'd3);

        // Jump to the JMP -1 at 0x100
        bus0.ir_ready = 1'b0;
        bus0.redir_valid = 1'b1; bus0.redir_pc4 = 32'h104; bus0.redir_imm = 16'hFFFF;
        tick();
        check("j_addr", bus0.imem_addr, 32'h100);
        bus0.redir_valid = 1'b0;
        tick();
        check("j_ir",     bus0.ir,     32'hA800_FFFF);
        check("j_pc4",    bus0.ir_pc4, 32'h104);
        check("j_halted", halted0,     32'd0);

        // Accept the JMP -1 together with its own redirect
        bus0.ir_ready = 1'b1;
        bus0.redir_valid = 1'b1; bus0.redir_pc4 = 32'h104; bus0.redir_imm = 16'hFFFF;
        tick();
        check("halt_halted", halted0,        32'd1);
        check("halt_addr",   bus0.imem_addr, 32'h100);
        check("halt_fc",     fc0,            32'd4);
        check("halt_valid",  bus0.ir_valid,  32'd0);
        bus0.redir_valid = 1'b0;
        for (int i = 0; i < 20; i++) begin
            tick();
            check("halt_sticky", halted0, 32'd1);
        end
        check("halt_fc_run", fc0, 32'd23);

        // PC wrap: redirect to 0xFFFFFFFC then fetch
        bus0.ir_ready = 1'b0;
        bus0.redir_valid = 1'b1; bus0.redir_pc4 = 32'h0; bus0.redir_imm = 16'hFFFF;
        tick();
        check("wrap_addr", bus0.imem_addr, 32'hFFFF_FFFC);
        bus0.redir_valid = 1'b0;
        tick();
        check("wrap_ir",   bus0.ir,        mem[255]);
        check("wrap_pc4",  bus0.ir_pc4,    32'h0);
        check("wrap_addr2",bus0.imem_addr, 32'h0);

        // Reset while stalled with a valid IR
        rst0 = 1'b1;
        tick();
        check("mrst_valid",  bus0.ir_valid,  32'd0);
        check("mrst_addr",   bus0.imem_addr, 32'h0);
        check("mrst_fc",     fc0,            32'd0);
        check("mrst_halted", halted0,        32'd0);
        rst0 = 1'b0;

        // ---- FETCH_WAIT=3 instance ----
        rst1 = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            check("fw3_lat_valid", bus1.ir_valid, 32'd0);
        end
        tick();
        check("fw3_first_valid", bus1.ir_valid, 32'd1);
        check("fw3_first_ir",    bus1.ir,       32'h0);
        check("fw3_first_pc4",   bus1.ir_pc4,   32'h4);
        bus1.ir_ready = 1'b1;
        tick();
        check("fw3_acc_valid", bus1.ir_valid, 32'd0);
        check("fw3_acc_fc",    fc1,           32'd1);
        bus1.ir_ready = 1'b0;
        tick();
        check("fw3_wait_valid", bus1.ir_valid, 32'd0);
        // Redirect in the middle of the wait window restarts the count
        bus1.redir_valid = 1'b1; bus1.redir_pc4 = 32'hC4; bus1.redir_imm = 16'hFFF1;
        tick();
        check("fw3_redir_addr",  bus1.imem_addr, 32'h88);
        check("fw3_redir_valid", bus1.ir_valid,  32'd0);
        bus1.redir_valid = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            check("fw3_rwait_valid", bus1.ir_valid, 32'd0);
        end
        tick();
        check("fw3_redir_valid2", bus1.ir_valid, 32'd1);
        check("fw3_redir_ir",     bus1.ir,       mem[34]);
        check("fw3_redir_pc4",    bus1.ir_pc4,   32'h8C);
        check("fw3_fc",           fc1,           32'd1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/instr_fetch_unit.md
Name: instr_fetch_unit

Overview:
- Fetch stage of the multicycle MIPS core; sits directly upstream of the combinational instruction memory.
- Owns the PC and drives the byte address to the memory (the memory discards addr[1:0]).
- Captures the returned word into an instruction register (IR) and hands it to decode over a valid/ready handshake.
- Accepts branch/jump redirects from execute and detects the program-terminating "JMP -1".

Parameters:
- RESET_PC, 32'h0000_0000, byte address loaded into PC on reset.
- FETCH_WAIT, 0, extra cycles to wait after PC changes before sampling imem_data (0 = same-cycle sample; reserved for a later SRAM-backed memory). Range 0..15.

Ports:
- clk  in  1  clock, all state on rising edge.
- rst  in  1  synchronous, active-high reset.
- imem_addr  out  32  byte address to instruction memory; always equals PC.
- imem_data  in  32  instruction word returned combinationally for imem_addr.
- ir  out  32  captured instruction.
- ir_pc4  out  32  byte address of the captured instruction + 4.
- ir_valid  out  1  ir/ir_pc4 hold an instruction not yet accepted.
- ir_ready  in  1  decode accepts when ir_valid && ir_ready.
- redir_valid  in  1  taken branch/jump this cycle.
- redir_pc4  in  32  ir_pc4 of the redirecting instruction.
- redir_imm  in  16  signed word offset from instruction bits [15:0].
- halted  out  1  sticky; a JMP -1 has been accepted by decode.
- fetch_count  out  32  number of accepted instructions.

Behaviour:
- Clock is clk. Reset is synchronous and active-high on rst. Reset wins over all other inputs, including mid-wait and mid-handshake.
- Reset values:
  - PC = RESET_PC; ir = 0; ir_pc4 = 0; ir_valid = 0; halted = 0; fetch_count = 0.
  - state = WAIT; wait counter cnt = 0.
- State WAIT (ir_valid = 0):
  - If cnt == FETCH_WAIT: ir <= imem_data; ir_pc4 <= PC+4; PC <= PC+4; go to FULL.
  - Otherwise cnt <= cnt+1.
- State FULL (ir_valid = 1):
  - If ir_ready and FETCH_WAIT == 0: capture the next word as in WAIT and stay in FULL (one instruction per cycle).
  - If ir_ready and FETCH_WAIT > 0: cnt <= 0; go to WAIT.
  - If !ir_ready: ir, ir_pc4 and PC hold stable.
- Latency: the first ir_valid is asserted FETCH_WAIT+1 cycles after reset deasserts.
- Handshake: ir and ir_pc4 must not change while ir_valid && !ir_ready. ir_valid never drops without acceptance except on redirect or reset.
- Redirect (redir_valid = 1, any state), priority over normal fetch:
  - target = {redir_pc4[31:2] + sext32(redir_imm), 2'b00}, i.e. pc4 + imm*4, mod 2^32. redir_pc4[1:0] is ignored.
  - PC <= target; ir_valid <= 0; cnt <= 0; state <= WAIT.
  - Any IR contents are discarded.
- Simultaneous redirect and ir_valid && ir_ready: the handshake completes (counted, halted check applies); the redirect still wins for PC and the next state.
- Accept side effects: on each accepted handshake fetch_count <= fetch_count+1 (wraps at 2^32).
- Halt detection: if the accepted ir == 32'hA800_FFFF (opcode 101010, imm -1), halted <= 1. It stays 1 until reset. Fetch keeps running; the core stops on halted.
- PC wraps 32'hFFFF_FFFC -> 0 without any flag.
- No opcode decoding beyond halt detection.

Test Plan:
- Reset with FETCH_WAIT=0, ir_ready=1, memory preloaded with the bring-up program -> cycle 1: imem_addr=0, ir_valid=1, ir=0, ir_pc4=4. Next: ir=0x8001060A, ir_pc4=8. fetch_count increments each cycle.
- Hold ir_ready=0 for 5 cycles while ir_valid=1 -> ir, ir_pc4 and imem_addr unchanged. Release -> next word follows with no lost or duplicated instruction.
- BNE redirect: redir_valid=1, redir_pc4=0xC4, redir_imm=0xFFF1 -> next imem_addr=0x88; ir_valid=0 that cycle-after; then ir from word 34 with ir_pc4=0x8C.
- JMP -1: ir=0xA800FFFF accepted with simultaneous redir_valid, redir_pc4=0x104, redir_imm=0xFFFF -> halted=1, imem_addr=0x100, fetch_count incremented; halted stays 1 over 20 further cycles.
- FETCH_WAIT=3 -> first ir_valid 4 cycles after reset. A redirect during WAIT restarts cnt, and the redirected word appears 4 cycles after the redirect.
- Assert rst mid-stall (ir_valid=1, ir_ready=0) -> next cycle ir_valid=0, imem_addr=RESET_PC, fetch_count=0, halted=0.
